// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_pkg
// Brief    : Shared fetch-stage definitions: state encodings, word size, NOP.
// Revision : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

    typedef enum logic [1:0] {
        IF_IDLE    = 2'd0,
        IF_REQ     = 2'd1,
        IF_DISCARD = 2'd2
    } if_state_e;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] instr;
    } if_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~(WORD_BYTES - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_skid.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_skid
// Brief    : One-entry npc+instr holding buffer with push/pop/clear.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_skid
    import if_fetch_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      clear,
    input  if_entry_t din,
    output if_entry_t dout,
    output logic      full
);

    if_entry_t r_entry_q, w_entry_d;
    logic      r_full_q,  w_full_d;

    always_comb begin
        w_entry_d = r_entry_q;
        w_full_d  = r_full_q;
        if (clear) begin
            w_full_d = 1'b0;
        end else if (push) begin
            w_entry_d = din;
            w_full_d  = 1'b1;
        end else if (pop) begin
            w_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry_q <= '0;
            r_full_q  <= 1'b0;
        end else begin
            r_entry_q <= w_entry_d;
            r_full_q  <= w_full_d;
        end
    end

    assign dout = r_entry_q;
    assign full = r_full_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : Instruction fetch stage with req/ack memory port, skid buffer and
//            branch redirect. Optional IF_BPC_ALIGN_CHECK_EN adds IF_adel.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_bpc,
    input  logic        EX_branch_taken,
    input  logic        IF_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        IF_valid,
    output logic [31:0] IF_npc,
    output logic [31:0] IF_instr
`ifdef IF_BPC_ALIGN_CHECK_EN
    ,
    output logic        IF_adel
`endif
);

    if_state_e   r_state_q, w_state_d;
    logic [31:0] r_pc_q,    w_pc_d;
    logic        r_req_q,   w_req_d;
    logic [31:0] r_addr_q,  w_addr_d;
    logic        r_valid_q, w_valid_d;
    logic [31:0] r_npc_q,   w_npc_d;
    logic [31:0] r_instr_q, w_instr_d;

    logic        w_skid_push;
    logic        w_skid_pop;
    logic        w_skid_clear;
    logic        w_skid_full;
    if_entry_t   w_skid_din;
    if_entry_t   w_skid_dout;

    logic        w_ack;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign w_ack      = r_req_q & imem_ack;
    assign w_target   = align_word(EX_bpc);
    assign w_pc_inc   = r_pc_q + WORD_BYTES;
    assign w_skid_din = {w_pc_inc, imem_rdata};

    always_comb begin
        w_state_d    = r_state_q;
        w_pc_d       = r_pc_q;
        w_req_d      = r_req_q;
        w_addr_d     = r_addr_q;
        w_valid_d    = r_valid_q;
        w_npc_d      = r_npc_q;
        w_instr_d    = r_instr_q;
        w_skid_push  = 1'b0;
        w_skid_pop   = 1'b0;
        w_skid_clear = 1'b0;

        if (EX_branch_taken) begin
            w_pc_d       = w_target;
            w_valid_d    = 1'b0;
            w_skid_clear = 1'b1;
            // An unacknowledged request must finish its handshake before the new pc goes out.
            if (r_req_q && !imem_ack) begin
                w_state_d = IF_DISCARD;
            end else begin
                w_state_d = IF_REQ;
                w_req_d   = 1'b1;
                w_addr_d  = w_target;
            end
        end else begin
            case (r_state_q)
                IF_IDLE: begin
                    w_state_d = IF_REQ;
                    w_req_d   = 1'b1;
                    w_addr_d  = r_pc_q;
                end
                IF_REQ: begin
                    if (w_ack) begin
                        w_pc_d  = w_pc_inc;
                        w_req_d = 1'b0;
                        if (!IF_stall && !w_skid_full) begin
                            w_valid_d = 1'b1;
                            w_npc_d   = w_pc_inc;
                            w_instr_d = imem_rdata;
                        end else begin
                            w_skid_push = 1'b1;
                        end
                    end else if (!r_req_q && !w_skid_full) begin
                        w_req_d  = 1'b1;
                        w_addr_d = r_pc_q;
                    end
                end
                IF_DISCARD: begin
                    if (w_ack) begin
                        w_state_d = IF_REQ;
                        w_req_d   = 1'b0;
                    end
                end
                default: begin
                    w_state_d = IF_IDLE;
                    w_req_d   = 1'b0;
                end
            endcase

            // Cycles with no delivered memory data: drain the skid or go empty.
            if (!(r_state_q == IF_REQ && w_ack) && !IF_stall) begin
                if (w_skid_full) begin
                    w_skid_pop = 1'b1;
                    w_valid_d  = 1'b1;
                    w_npc_d    = w_skid_dout.npc;
                    w_instr_d  = w_skid_dout.instr;
                end else begin
                    w_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IF_IDLE;
            r_pc_q    <= RESET_PC;
            r_req_q   <= 1'b0;
            r_addr_q  <= 32'h0000_0000;
            r_valid_q <= 1'b0;
            r_npc_q   <= 32'h0000_0000;
            r_instr_q <= NOP_INSTR;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_req_q   <= w_req_d;
            r_addr_q  <= w_addr_d;
            r_valid_q <= w_valid_d;
            r_npc_q   <= w_npc_d;
            r_instr_q <= w_instr_d;
        end
    end

    if_fetch_skid u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (w_skid_push),
        .pop   (w_skid_pop),
        .clear (w_skid_clear),
        .din   (w_skid_din),
        .dout  (w_skid_dout),
        .full  (w_skid_full)
    );

`ifdef IF_BPC_ALIGN_CHECK_EN
    logic r_adel_q, w_adel_d;

    assign w_adel_d = EX_branch_taken & (EX_bpc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_adel_q <= 1'b0;
        end else begin
            r_adel_q <= w_adel_d;
        end
    end

    assign IF_adel = r_adel_q;
`endif

    assign imem_req  = r_req_q;
    assign imem_addr = r_addr_q;
    assign IF_valid  = r_valid_q;
    assign IF_npc    = r_npc_q;
    assign IF_instr  = r_instr_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Scenario-driven scoreboard bench for if_fetch.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_if_fetch;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, EX_branch_taken, IF_stall, imem_ack;
    logic [31:0] EX_bpc, imem_rdata;
    logic        imem_req, IF_valid;
    logic [31:0] imem_addr, IF_npc, IF_instr;

    logic        w_rst, w_ack, w_req, w_valid;
    logic [31:0] w_rdata, w_addr, w_npc, w_instr;
    logic        w_taken = 1'b0;
    logic        w_stall = 1'b0;
    logic [31:0] w_bpc   = 32'h0;
`ifdef IF_BPC_ALIGN_CHECK_EN
    logic        IF_adel, w_adel;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t e;
    bit   ok;

    if_fetch dut (
        .clk(clk), .rst(rst), .EX_bpc(EX_bpc), .EX_branch_taken(EX_branch_taken),
        .IF_stall(IF_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IF_valid(IF_valid),
        .IF_npc(IF_npc), .IF_instr(IF_instr)
`ifdef IF_BPC_ALIGN_CHECK_EN
        , .IF_adel(IF_adel)
`endif
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(w_rst), .EX_bpc(w_bpc), .EX_branch_taken(w_taken),
        .IF_stall(w_stall), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .IF_valid(w_valid),
        .IF_npc(w_npc), .IF_instr(w_instr)
`ifdef IF_BPC_ALIGN_CHECK_EN
        , .IF_adel(w_adel)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input bit wrap, output bit found);
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found) begin
                if ((wrap ? w_req : imem_req) === 1'b1) found = 1'b1;
                else cyc();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; w_rst = 1'b1; EX_branch_taken = 1'b0; EX_bpc = 32'h0;
        IF_stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; w_ack = 1'b0; w_rdata = 32'h0;
        cyc(); cyc();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            failures++; $display("FAIL reset_req: req=%b addr=%h, required 0 00000000", imem_req, imem_addr);
        end
        checks++;
        if (IF_valid !== 1'b0 || IF_npc !== 32'h0 || IF_instr !== 32'h0) begin
            failures++; $display("FAIL reset_out: valid=%b npc=%h instr=%h, required 0 0 0", IF_valid, IF_npc, IF_instr);
        end
`ifdef IF_BPC_ALIGN_CHECK_EN
        checks++;
        if (IF_adel !== 1'b0) begin
            failures++; $display("FAIL reset_adel: got %b, required 0", IF_adel);
        end
`endif
        rst = 1'b0;
        cyc();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++; $display("FAIL first_req: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_latency();
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        sb.push_back({32'd4, 32'h2008_0005});
        cyc();
        imem_ack = 1'b0;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL zl_out0: no expected entry"); end
        else begin
            e = sb.pop_front();
            if (IF_valid !== 1'b1 || IF_npc !== e.npc || IF_instr !== e.instr) begin
                failures++; $display("FAIL zl_out0: valid=%b npc=%h instr=%h, required 1 %h %h", IF_valid, IF_npc, IF_instr, e.npc, e.instr);
            end
        end
        checks++;
        if (imem_req !== 1'b0) begin
            failures++; $display("FAIL zl_gap: req=%b, required 0", imem_req);
        end
        wait_req(1'b0, ok);
        checks++;
        if (!ok || imem_addr !== 32'd4) begin
            failures++; $display("FAIL zl_next_addr: found=%b addr=%h, required 1 00000004", ok, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 32'h0123_4567;
        sb.push_back({32'd8, 32'h0123_4567});
        cyc();
        imem_ack = 1'b0;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL zl_out1: no expected entry"); end
        else begin
            e = sb.pop_front();
            if (IF_valid !== 1'b1 || IF_npc !== e.npc || IF_instr !== e.instr) begin
                failures++; $display("FAIL zl_out1: valid=%b npc=%h instr=%h, required 1 %h %h", IF_valid, IF_npc, IF_instr, e.npc, e.instr);
            end
        end
    endtask

    task automatic test_ack_latency();
        wait_req(1'b0, ok);
        checks++;
        if (!ok || imem_addr !== 32'd8 || IF_valid !== 1'b0) begin
            failures++; $display("FAIL lat_addr: found=%b addr=%h valid=%b, required 1 00000008 0", ok, imem_addr, IF_valid);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'd8 || IF_valid !== 1'b0) begin
                failures++; $display("FAIL lat_hold%0d: req=%b addr=%h valid=%b, required 1 00000008 0", i, imem_req, imem_addr, IF_valid);
            end
        end
        imem_ack = 1'b1; imem_rdata = 32'h8C22_0010;
        sb.push_back({32'd12, 32'h8C22_0010});
        cyc();
        imem_ack = 1'b0;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL lat_out: no expected entry"); end
        else begin
            e = sb.pop_front();
            if (IF_valid !== 1'b1 || IF_npc !== e.npc || IF_instr !== e.instr) begin
                failures++; $display("FAIL lat_out: valid=%b npc=%h instr=%h, required 1 %h %h", IF_valid, IF_npc, IF_instr, e.npc, e.instr);
            end
        end
    endtask

    task automatic test_stall_skid();
        IF_stall = 1'b1;
        wait_req(1'b0, ok);
        checks++;
        if (!ok || imem_addr !== 32'd12 || IF_valid !== 1'b1 || IF_instr !== 32'h8C22_0010) begin
            failures++; $display("FAIL stall_pre: found=%b addr=%h valid=%b instr=%h, required 1 0000000c 1 8c220010", ok, imem_addr, IF_valid, IF_instr);
        end
        imem_ack = 1'b1; imem_rdata = 32'hAC43_0004;
        sb.push_back({32'd16, 32'hAC43_0004});
        cyc();
        imem_ack = 1'b0;
        checks++;
        if (IF_valid !== 1'b1 || IF_npc !== 32'd12 || IF_instr !== 32'h8C22_0010) begin
            failures++; $display("FAIL stall_hold: valid=%b npc=%h instr=%h, required 1 0000000c 8c220010", IF_valid, IF_npc, IF_instr);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (imem_req !== 1'b0 || IF_instr !== 32'h8C22_0010) begin
                failures++; $display("FAIL skid_noreq%0d: req=%b instr=%h, required 0 8c220010", i, imem_req, IF_instr);
            end
        end
        IF_stall = 1'b0;
        cyc();
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL skid_drain: no expected entry"); end
        else begin
            e = sb.pop_front();
            if (IF_valid !== 1'b1 || IF_npc !== e.npc || IF_instr !== e.instr) begin
                failures++; $display("FAIL skid_drain: valid=%b npc=%h instr=%h, required 1 %h %h", IF_valid, IF_npc, IF_instr, e.npc, e.instr);
            end
        end
        wait_req(1'b0, ok);
        checks++;
        if (!ok || imem_addr !== 32'd16) begin
            failures++; $display("FAIL skid_next_addr: found=%b addr=%h, required 1 00000010", ok, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        sb.push_back({32'd20, 32'h0000_0013});
        cyc();
        imem_ack = 1'b0;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL skid_after: no expected entry"); end
        else begin
            e = sb.pop_front();
            if (IF_valid !== 1'b1 || IF_npc !== e.npc || IF_instr !== e.instr) begin
                failures++; $display("FAIL skid_after: valid=%b npc=%h instr=%h, required 1 %h %h", IF_valid, IF_npc, IF_instr, e.npc, e.instr);
            end
        end
    endtask

    task automatic test_redirect();
        IF_stall = 1'b1;
        wait_req(1'b0, ok);
        checks++;
        if (!ok || imem_addr !== 32'd20 || IF_valid !== 1'b1) begin
            failures++; $display("FAIL redir_pre: found=%b addr=%h valid=%b, required 1 00000014 1", ok, imem_addr, IF_valid);
        end
        EX_branch_taken = 1'b1; EX_bpc = 32'h0000_0339;
        cyc();
        EX_branch_taken = 1'b0; IF_stall = 1'b0;
        checks++;
        if (IF_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd20) begin
            failures++; $display("FAIL redir_hold: valid=%b req=%b addr=%h, required 0 1 00000014", IF_valid, imem_req, imem_addr);
        end
`ifdef IF_BPC_ALIGN_CHECK_EN
        checks++;
        if (IF_adel !== 1'b1) begin
            failures++; $display("FAIL adel_pulse: got %b, required 1", IF_adel);
        end
`endif
        cyc();
`ifdef IF_BPC_ALIGN_CHECK_EN
        checks++;
        if (IF_adel !== 1'b0) begin
            failures++; $display("FAIL adel_one_cycle: got %b, required 0", IF_adel);
        end
`endif
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd20) begin
            failures++; $display("FAIL disc_stable: req=%b addr=%h, required 1 00000014", imem_req, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        imem_ack = 1'b0;
        checks++;
        if (IF_valid !== 1'b0) begin
            failures++; $display("FAIL disc_drop: valid=%b instr=%h, required valid 0", IF_valid, IF_instr);
        end
        wait_req(1'b0, ok);
        checks++;
        if (!ok || imem_addr !== 32'h0000_0338) begin
            failures++; $display("FAIL redir_addr: found=%b addr=%h, required 1 00000338", ok, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 32'h2402_0001;
        sb.push_back({32'h0000_033C, 32'h2402_0001});
        cyc();
        imem_ack = 1'b0;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL redir_out: no expected entry"); end
        else begin
            e = sb.pop_front();
            if (IF_valid !== 1'b1 || IF_npc !== e.npc || IF_instr !== e.instr) begin
                failures++; $display("FAIL redir_out: valid=%b npc=%h instr=%h, required 1 %h %h", IF_valid, IF_npc, IF_instr, e.npc, e.instr);
            end
        end
    endtask

    task automatic test_redirect_ack_stall();
        IF_stall = 1'b1;
        wait_req(1'b0, ok);
        checks++;
        if (!ok || imem_addr !== 32'h0000_033C) begin
            failures++; $display("FAIL ras_pre: found=%b addr=%h, required 1 0000033c", ok, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        EX_branch_taken = 1'b1; EX_bpc = 32'h0000_0100;
        cyc();
        imem_ack = 1'b0; EX_branch_taken = 1'b0;
        checks++;
        if (IF_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
            failures++; $display("FAIL ras_next: valid=%b req=%b addr=%h, required 0 1 00000100", IF_valid, imem_req, imem_addr);
        end
`ifdef IF_BPC_ALIGN_CHECK_EN
        cyc();
        checks++;
        if (IF_adel !== 1'b0) begin
            failures++; $display("FAIL ras_adel: got %b, required 0", IF_adel);
        end
`endif
        IF_stall = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h3C01_1000;
        sb.push_back({32'h0000_0104, 32'h3C01_1000});
        cyc();
        imem_ack = 1'b0;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL ras_out: no expected entry"); end
        else begin
            e = sb.pop_front();
            if (IF_valid !== 1'b1 || IF_npc !== e.npc || IF_instr !== e.instr) begin
                failures++; $display("FAIL ras_out: valid=%b npc=%h instr=%h, required 1 %h %h", IF_valid, IF_npc, IF_instr, e.npc, e.instr);
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_req(1'b0, ok);
        rst = 1'b1;
        cyc();
        checks++;
        if (!ok || imem_req !== 1'b0 || IF_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid: found=%b req=%b valid=%b, required 1 0 0", ok, imem_req, IF_valid);
        end
        rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        cyc();
        imem_ack = 1'b0;
        checks++;
        if (IF_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++; $display("FAIL rst_late_ack: valid=%b req=%b addr=%h, required 0 1 00000000", IF_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        w_rst = 1'b0;
        wait_req(1'b1, ok);
        checks++;
        if (!ok || w_addr !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_first: found=%b addr=%h, required 1 fffffffc", ok, w_addr);
        end
        w_ack = 1'b1; w_rdata = 32'h1111_0001;
        sb.push_back({32'h0000_0000, 32'h1111_0001});
        cyc();
        w_ack = 1'b0;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL wrap_out0: no expected entry"); end
        else begin
            e = sb.pop_front();
            if (w_valid !== 1'b1 || w_npc !== e.npc || w_instr !== e.instr) begin
                failures++; $display("FAIL wrap_out0: valid=%b npc=%h instr=%h, required 1 %h %h", w_valid, w_npc, w_instr, e.npc, e.instr);
            end
        end
        wait_req(1'b1, ok);
        checks++;
        if (!ok || w_addr !== 32'h0) begin
            failures++; $display("FAIL wrap_addr: found=%b addr=%h, required 1 00000000", ok, w_addr);
        end
        w_ack = 1'b1; w_rdata = 32'h2222_0002;
        sb.push_back({32'h0000_0004, 32'h2222_0002});
        cyc();
        w_ack = 1'b0;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL wrap_out1: no expected entry"); end
        else begin
            e = sb.pop_front();
            if (w_valid !== 1'b1 || w_npc !== e.npc || w_instr !== e.instr) begin
                failures++; $display("FAIL wrap_out1: valid=%b npc=%h instr=%h, required 1 %h %h", w_valid, w_npc, w_instr, e.npc, e.instr);
            end
        end
        wait_req(1'b1, ok);
        w_rst = 1'b1;
        cyc();
        checks++;
        if (!ok || w_req !== 1'b0) begin
            failures++; $display("FAIL wrap_rst: found=%b req=%b, required 1 0", ok, w_req);
        end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_ack_latency();
        test_stall_skid();
        test_redirect();
        test_redirect_ack_stall();
        test_reset_mid();
        test_wrap();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL sb_leftover: %0d entries, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage: owns the PC, drives the instruction-memory request/acknowledge handshake and produces the IF/ID outputs IF_npc and IF_instr.
- Consumes the branch target EX_bpc computed in EX and redirects fetch on EX_branch_taken.
- Absorbs decode stalls with a one-entry skid buffer.
- Discards in-flight fetches made stale by a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- EX_bpc  in  32  branch target from EX stage
- EX_branch_taken  in  1  redirect strobe, one cycle per taken branch
- IF_stall  in  1  hazard unit: hold IF/ID outputs
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch byte address
- imem_ack  in  1  request accepted, data valid this cycle
- imem_rdata  in  32  instruction word, valid with imem_ack
- IF_valid  out  1  IF_instr/IF_npc hold a live instruction
- IF_npc  out  32  fetch address + 4
- IF_instr  out  32  fetched instruction

Behaviour:
- Reset: pc=RESET_PC, imem_req=0, imem_addr=0, IF_valid=0, IF_npc=0, IF_instr=0, skid empty, state=IDLE. Reset mid-transaction abandons it; a late imem_ack after reset is ignored in IDLE.
- States:
  - IDLE: first cycle after reset.
  - REQ: request outstanding.
  - DISCARD: request outstanding, but a redirect makes its data stale.
- IDLE→REQ unconditionally. Next cycle imem_req=1, imem_addr=pc.
- REQ handshake:
  - imem_req and imem_addr stay stable until imem_ack.
  - Response latency is arbitrary, 0 or more cycles after req.
  - On ack: pc<=pc+4; the next request presents pc+4 in the following cycle, giving 1 instruction per 2 cycles minimum.
- Ack delivery:
  - If IF_stall=0 and the skid is empty: IF_instr<=imem_rdata, IF_npc<=pc+4, IF_valid<=1.
  - If IF_stall=1: data goes to the skid buffer and the outputs hold.
- No ack and IF_stall=0: IF_valid<=0, unless the skid is full, in which case the skid moves to the outputs.
- Skid full:
  - imem_req=0; no new request until the skid drains.
  - It drains on the first cycle with IF_stall=0.
  - Skid-to-output has priority over the next memory data.
- Outputs hold whenever IF_stall=1.
- Redirect (EX_branch_taken=1) has priority over IF_stall:
  - pc<=EX_bpc with bits [1:0] forced to 0.
  - IF_valid<=0 and the skid is cleared.
  - If a request is outstanding and imem_ack=0 that cycle: go to DISCARD; req stays stable until ack; the data is dropped; then REQ at the new pc.
  - If ack coincides with the redirect: the data is dropped and pc+4 is not applied; the next cycle requests EX_bpc.
  - A redirect while in DISCARD overwrites the target pc and the state stays DISCARD.
- Wrap-around: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC→0), no flag.
- Arithmetic is 32-bit unsigned; carries are discarded.

Optional Feature:
- Macro IF_BPC_ALIGN_CHECK_EN.
- Defined: adds output IF_adel (1-bit). It pulses high for exactly one cycle, the cycle after a redirect with EX_bpc[1:0]!=0. The pc is still loaded with bits [1:0] cleared. Reset value 0.
- Undefined: the port is absent and misaligned targets are silently truncated.

Decomposition:
- Shared header if_defs.v, reused by ID/EX:
  - state encodings IF_IDLE/IF_REQ/IF_DISCARD (2-bit);
  - WORD_BYTES=4;
  - NOP_INSTR=32'h0000_0000.
- One sub-module, if_skid: a 1-entry, 64-bit (npc+instr) buffer with push/pop/clear and a full flag.

Test Plan:
- Reset then zero-latency ack, rdata=32'h2008_0005: imem_addr=0, then IF_instr=32'h2008_0005, IF_npc=4, IF_valid=1; next imem_addr=4.
- Ack delayed 3 cycles at addr 8: imem_req/imem_addr=8 stable for 4 cycles; IF_valid=0 until the ack cycle+1.
- IF_stall=1 when ack for addr 12 arrives: outputs hold the previous instr; imem_req=0 while the skid is full; stall drop→IF_npc=16 next cycle, then request 16.
- Redirect EX_bpc=32'h0000_0339 while the addr-20 request is pending: ack data dropped, IF_valid=0, next imem_addr=32'h0000_0338; IF_adel=1 for one cycle if the macro is defined.
- Redirect coincident with ack and IF_stall=1: IF_valid=0, skid empty, next request=EX_bpc.
- RESET_PC=32'hFFFF_FFFC, two acks: second request at 0; rst asserted mid-request→imem_req=0 the next cycle.
